seq_div: RTL and testbench
==========================

SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand, quotient and remainder width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: operand-valid strobe; while high, the block loads a and b and initialises.
REQ-005 The block SHALL have port a, input, WIDTH bits: dividend, two's complement.
REQ-006 The block SHALL have port b, input, WIDTH bits: divisor, two's complement.
REQ-007 The block SHALL have port q, output, WIDTH bits: quotient, two's complement, registered.
REQ-008 The block SHALL have port r, output, WIDTH bits: remainder, two's complement, registered.
REQ-009 The block SHALL have port done, output, 1 bit: q, r and flags are valid; held high until the next start or reset.
REQ-010 The block SHALL have port div_by_zero, output, 1 bit: the captured b was zero.
REQ-011 The block SHALL have port ovf, output, 1 bit: the true quotient is not representable in WIDTH bits.

Function
REQ-012 The block SHALL implement the FSM states IDLE, LOAD, RUN, FIX and DONE.
REQ-013 On any edge with start=1 (and reset=0), the block SHALL perform the following, from any state:
- capture |a|, |b|, sign(a), sign(b) and b==0;
- clear done, div_by_zero, ovf, q and r;
- clear the iteration counter;
- go to LOAD.
REQ-014 In LOAD with start=0, the block SHALL go to RUN, or go to FIX if the captured b==0.
REQ-015 In RUN, each cycle SHALL perform one unsigned restoring-division step on the magnitudes:
- shift partial remainder left, bringing in the next dividend bit, MSB first;
- subtract |b|;
- if the result is non-negative, keep it and set quotient bit 1;
- otherwise restore and set quotient bit 0.
REQ-016 The iteration counter SHALL be WIDTH-bit-count + 1 wide, so it cannot wrap before the exit compare; RUN SHALL exit to FIX after exactly WIDTH steps.
REQ-017 In FIX, the block SHALL apply signs and load the outputs:
- q = magnitude quotient, negated if sign(a) XOR sign(b);
- r = magnitude remainder, negated if sign(a);
- truncation is toward zero; r has the sign of a or is zero;
- then go to DONE with done=1.
REQ-018 For a divide by zero, FIX SHALL output q = all ones, r = a, div_by_zero=1, ovf=0.
REQ-019 When the magnitude quotient exceeds 2^(WIDTH-1)-1 with a positive result sign (only a = -2^(WIDTH-1), b = -1), the block SHALL output q = 2^(WIDTH-1) bit pattern, r = 0, ovf=1.
REQ-020 Latency SHALL be: with start high for one cycle at edge N, done rises at edge N+WIDTH+2 (10 cycles for WIDTH=8); for b==0, done rises at edge N+2.
REQ-021 In DONE, outputs SHALL hold stable until start or reset.
REQ-022 While start is held high across multiple cycles, the block SHALL keep reloading; computation begins on the first edge after start falls.
REQ-023 Start asserted during RUN or FIX SHALL abort the current division and discard its results.
REQ-024 Magnitude arithmetic SHALL use WIDTH+1 bits so |-2^(WIDTH-1)| is represented exactly.

Reset
REQ-025 reset=1 SHALL force state IDLE and q=0, r=0, done=0, div_by_zero=0, ovf=0, counter=0 on the next edge.
REQ-026 reset SHALL take priority over start; reset mid-RUN SHALL abandon the operation with no done pulse.
REQ-027 IDLE SHALL remain idle, with outputs at reset values, until start.

Verification
REQ-028 The bench SHALL cover: a=100, b=7, start 1 cycle -> done 10 cycles later, q=14 (0x0E), r=2.
REQ-029 The bench SHALL cover: a=-100 (0x9C), b=7 -> q=-14 (0xF2), r=-2 (0xFE); and a=100, b=-7 -> q=0xF2, r=2.
REQ-030 The bench SHALL cover: a=-128 (0x80), b=-1 (0xFF) -> q=0x80, r=0, ovf=1; and a=-128, b=1 -> q=0x80, ovf=0.
REQ-031 The bench SHALL cover: a=5, b=0 -> done 2 cycles after start edge, q=0xFF, r=5, div_by_zero=1.
REQ-032 The bench SHALL cover: a=100, b=7 started, then 3 cycles later start with a=9, b=2 -> only one done, q=4, r=1, 10 cycles after the second start.
REQ-033 The bench SHALL cover: reset asserted mid-RUN -> all outputs 0 next edge, done stays 0; a subsequent start with a=-7, b=2 -> q=-3 (0xFD), r=-1 (0xFF).

Source files
------------

// File: rtl/seq_div.sv
// Sequential signed restoring divider: one quotient bit per clock on operand
// magnitudes, with signs, divide-by-zero and the single overflow case applied in FIX.
module seq_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             done,
    output logic             div_by_zero,
    output logic             ovf
);

    // state  | meaning
    // IDLE   | after reset, outputs zero, waiting for start
    // LOAD   | operands captured, start may still be held
    // RUN    | one restoring step per cycle, WIDTH steps
    // FIX    | apply signs / special cases, load outputs
    // DONE   | results held until start or reset
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_FIX, S_DONE} state_t;

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH:0]   r_bmag;
    logic [WIDTH-1:0] r_a;
    logic             r_sa;
    logic             r_sb;
    logic             r_bz;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_done;
    logic             r_dz;
    logic             r_ovf;

    // An unsigned WIDTH-bit field already holds 2^(WIDTH-1), so |a| needs no extra bit.
    logic [WIDTH-1:0] w_amag;
    logic [WIDTH:0]   w_bmag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_sub;
    logic             w_ge;
    logic             w_last;
    logic             w_neg_q;
    logic             w_ovf;
    logic [WIDTH-1:0] w_q_neg;
    logic [WIDTH-1:0] w_r_neg;

    assign w_amag  = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign w_bmag  = b[WIDTH-1] ? -{b[WIDTH-1], b} : {b[WIDTH-1], b};
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= r_bmag);
    assign w_sub   = w_shift[WIDTH-1:0] - r_bmag[WIDTH-1:0];
    assign w_last  = (r_cnt == CW'(WIDTH - 1));
    assign w_neg_q = r_sa ^ r_sb;
    assign w_ovf   = ~w_neg_q & r_quo[WIDTH-1];
    assign w_q_neg = ~r_quo + 1'b1;
    assign w_r_neg = ~r_rem + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = S_IDLE;
            S_LOAD:  w_next = r_bz ? S_FIX : S_RUN;
            S_RUN:   w_next = w_last ? S_FIX : S_RUN;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
        if (start) begin
            w_next = S_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_bmag <= '0;
            r_a    <= '0;
            r_sa   <= 1'b0;
            r_sb   <= 1'b0;
            r_bz   <= 1'b0;
            r_q    <= '0;
            r_r    <= '0;
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (start) begin
            r_cnt  <= '0;
            r_quo  <= w_amag;
            r_rem  <= '0;
            r_bmag <= w_bmag;
            r_a    <= a;
            r_sa   <= a[WIDTH-1];
            r_sb   <= b[WIDTH-1];
            r_bz   <= (b == '0);
            r_q    <= '0;
            r_r    <= '0;
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (r_bz) begin
                        r_q  <= '1;
                        r_r  <= r_a;
                        r_dz <= 1'b1;
                    end else if (w_ovf) begin
                        r_q   <= r_quo;
                        r_r   <= '0;
                        r_ovf <= 1'b1;
                    end else begin
                        r_q <= w_neg_q ? w_q_neg : r_quo;
                        r_r <= r_sa ? w_r_neg : r_rem;
                    end
                end
                default: ;
            endcase
        end
    end

    assign q           = r_q;
    assign r           = r_r;
    assign done        = r_done;
    assign div_by_zero = r_dz;
    assign ovf         = r_ovf;

endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: arithmetic reference model checked every cycle, plus
// directed operations with literal expected results and latencies.
module tb_seq_div;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         done;
    logic         div_by_zero;
    logic         ovf;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_div #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .q(q), .r(r), .done(done), .div_by_zero(div_by_zero), .ovf(ovf)
    );

    // Returns {div_by_zero, ovf, q, r} from plain signed arithmetic.
    function automatic logic [2*W+1:0] model(input logic [W-1:0] aa, input logic [W-1:0] bb);
        int sa;
        int sb;
        int qi;
        int ri;
        sa = $signed(aa);
        sb = $signed(bb);
        if (sb == 0) return {1'b1, 1'b0, {W{1'b1}}, aa};
        if (sa == -(2 ** (W - 1)) && sb == -1) return {1'b0, 1'b1, W'(2 ** (W - 1)), W'(0)};
        qi = sa / sb;
        ri = sa % sb;
        return {1'b0, 1'b0, W'(qi), W'(ri)};
    endfunction

    // Model state: which operation (if any) is in flight and when it started.
    int           cyc = 0;
    int           st_cyc = 0;
    bit           known = 1'b0;
    bit           valid = 1'b0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            known <= 1'b1;
            valid <= 1'b0;
        end else if (start) begin
            valid  <= 1'b1;
            st_cyc <= cyc + 1;
            m_a    <= a;
            m_b    <= b;
        end
    end

    logic [2*W+2:0] exp_v;
    logic [2*W+2:0] act_v;
    bit             exp_done;

    always @(negedge clk) begin
        if (known) begin
            exp_done = valid && ((cyc - st_cyc) >= ((m_b == '0) ? 2 : W + 2));
            exp_v    = exp_done ? {1'b1, model(m_a, m_b)} : '0;
            act_v    = {done, div_by_zero, ovf, q, r};
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL cycle_check cyc=%0d {done,dz,ovf,q,r} got %h expected %h (a=%h b=%h)",
                         cyc, act_v, exp_v, m_a, m_b);
            end
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edz, input logic eovf, input int elat,
                          input string name);
        int n;
        @(negedge clk);
        a     = ta;
        b     = tb_b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (done !== 1'b1 || n != elat || q !== eq || r !== er ||
            div_by_zero !== edz || ovf !== eovf) begin
            fails++;
            $display("FAIL %s: got done=%b lat=%0d q=%h r=%h dz=%b ovf=%b, expected lat=%0d q=%h r=%h dz=%b ovf=%b",
                     name, done, n, q, r, div_by_zero, ovf, elat, eq, er, edz, eovf);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_op(8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0, 10, "pos_pos");
        run_op(8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0, 10, "neg_pos");
        run_op(8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0, 10, "pos_neg");
        run_op(8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1, 10, "ovf_case");
        run_op(8'h80,  8'h01,  8'h80, 8'h00, 1'b0, 1'b0, 10, "min_by_one");
        run_op(8'd5,   8'd0,   8'hFF, 8'h05, 1'b1, 1'b0, 2,  "div_zero");

        // Abort: second start three cycles after the first.
        @(negedge clk);
        a = 8'd100; b = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        run_op(8'd9, 8'd2, 8'h04, 8'h01, 1'b0, 1'b0, 10, "abort_restart");

        // Reset in the middle of RUN.
        @(negedge clk);
        a = 8'd100; b = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if ({done, div_by_zero, ovf, q, r} !== '0) begin
            fails++;
            $display("FAIL reset_mid_run: outputs got %h expected 0", {done, div_by_zero, ovf, q, r});
        end
        repeat (12) @(negedge clk);
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_done: done got %b expected 0", done);
        end
        run_op(8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 1'b0, 10, "after_reset");

        // Start held for three cycles, operands changing; last load wins.
        @(negedge clk);
        a = 8'd50; b = 8'd3; start = 1'b1;
        @(negedge clk);
        a = 8'd77;
        run_op(8'hF7, 8'd4, 8'hFE, 8'hFF, 1'b0, 1'b0, 10, "held_start");

        // Random operations with random gaps (some abort) and occasional resets.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            a = W'($urandom);
            if ($urandom_range(0, 7) == 0) a = 8'h80;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = '1;
                2:       b = 8'd1;
                default: b = W'($urandom);
            endcase
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat ($urandom_range(0, 13)) @(negedge clk);
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        end

        repeat (15) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
